// File: rtl/mux_scan_nx1.sv
// Registered N:1 channel multiplexer with manual select or round-robin scan,
// a programmable dwell between samples and a valid/ready output port.
module mux_scan_nx1 #(
    parameter int unsigned  SIZE  = 8,
    parameter int unsigned  WIDTH = 4,
    parameter int unsigned  DWELL = 2,
    localparam int unsigned SW    = $clog2(SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SIZE*WIDTH-1:0] mux_scan_in,
    input  logic                  mux_scan_en,
    input  logic                  mux_scan_mode,
    input  logic [SW-1:0]         mux_scan_sel,
    input  logic                  mux_scan_ready,
    output logic [WIDTH-1:0]      mux_scan_out,
    output logic [SW-1:0]         mux_scan_ch,
    output logic                  mux_scan_err,
    output logic                  mux_scan_valid
);

    localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESENT,
        ST_DWELL
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [SW-1:0]    ch_q, ch_d;
    logic             err_q, err_d;
    logic             valid_q, valid_d;
    logic [SW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             xfer_c;
    logic [SW-1:0]    ptr_wrap_c;
    logic [SW-1:0]    cap_ch_c;
    logic             cap_err_c;
    logic [WIDTH-1:0] cap_data_c;

    // Capture source; a transfer edge advances the pointer before a back-to-back capture.
    always_comb begin
        xfer_c     = (state_q == ST_PRESENT) && mux_scan_ready;
        ptr_wrap_c = (32'(ch_q) >= SIZE - 1) ? '0 : ch_q + SW'(1);
        cap_ch_c   = mux_scan_mode ? (xfer_c ? ptr_wrap_c : ptr_q) : mux_scan_sel;
        cap_err_c  = !mux_scan_mode && (32'(mux_scan_sel) >= SIZE);
        cap_data_c = '0;
        for (int k = 0; k < int'(SIZE); k++) begin
            if (!cap_err_c && (cap_ch_c == SW'(k))) begin
                cap_data_c = mux_scan_in[k*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        logic capture;
        state_d = state_q;
        out_d   = out_q;
        ch_d    = ch_q;
        err_d   = err_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        capture = 1'b0;

        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                capture = mux_scan_en;
            end
            ST_PRESENT: begin
                if (mux_scan_ready) begin
                    ptr_d   = ptr_wrap_c;
                    valid_d = 1'b0;
                    if (!mux_scan_en) begin
                        state_d = ST_IDLE;
                    end else if (DWELL == 0) begin
                        capture = 1'b1;
                    end else begin
                        cnt_d   = CW'(DWELL - 1);
                        state_d = ST_DWELL;
                    end
                end
            end
            ST_DWELL: begin
                if (!mux_scan_en) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    capture = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (capture) begin
            state_d = ST_PRESENT;
            valid_d = 1'b1;
            ch_d    = cap_ch_c;
            err_d   = cap_err_c;
            out_d   = cap_data_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            ch_q    <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            ch_q    <= ch_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mux_scan_out   = out_q;
    assign mux_scan_ch    = ch_q;
    assign mux_scan_err   = err_q;
    assign mux_scan_valid = valid_q;

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Bench for mux_scan_nx1: three configurations share one stimulus stream and
// each is compared every cycle against a sample-level reference model.
module tb_mux_scan_nx1;

    localparam int NI = 3;

    int sz [NI] = '{8, 8, 5};
    int dw [NI] = '{2, 0, 1};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_v;
    logic        en, mode, ready;
    logic [2:0]  sel;

    logic [3:0] a_out, b_out, c_out;
    logic [2:0] a_ch, b_ch, c_ch;
    logic       a_err, b_err, c_err;
    logic       a_valid, b_valid, c_valid;

    always #5 clk = ~clk;

    mux_scan_nx1 #(.SIZE(8), .WIDTH(4), .DWELL(2)) u_a (
        .clk(clk), .rst_n(rst_n), .mux_scan_in(in_v), .mux_scan_en(en),
        .mux_scan_mode(mode), .mux_scan_sel(sel), .mux_scan_ready(ready),
        .mux_scan_out(a_out), .mux_scan_ch(a_ch), .mux_scan_err(a_err),
        .mux_scan_valid(a_valid)
    );

    mux_scan_nx1 #(.SIZE(8), .WIDTH(4), .DWELL(0)) u_b (
        .clk(clk), .rst_n(rst_n), .mux_scan_in(in_v), .mux_scan_en(en),
        .mux_scan_mode(mode), .mux_scan_sel(sel), .mux_scan_ready(ready),
        .mux_scan_out(b_out), .mux_scan_ch(b_ch), .mux_scan_err(b_err),
        .mux_scan_valid(b_valid)
    );

    mux_scan_nx1 #(.SIZE(5), .WIDTH(4), .DWELL(1)) u_c (
        .clk(clk), .rst_n(rst_n), .mux_scan_in(in_v[19:0]), .mux_scan_en(en),
        .mux_scan_mode(mode), .mux_scan_sel(sel), .mux_scan_ready(ready),
        .mux_scan_out(c_out), .mux_scan_ch(c_ch), .mux_scan_err(c_err),
        .mux_scan_valid(c_valid)
    );

    // Reference model: a pending sample, an idle flag, and idle cycles still owed.
    int m_out  [NI];
    int m_ch   [NI];
    int m_ptr  [NI];
    int m_left [NI];
    bit m_err  [NI];
    bit m_valid[NI];
    bit m_idle [NI];

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NI; i++) begin
            m_out[i] = 0; m_ch[i] = 0; m_ptr[i] = 0; m_left[i] = 0;
            m_err[i] = 1'b0; m_valid[i] = 1'b0; m_idle[i] = 1'b1;
        end
    endfunction

    function automatic void model_step();
        for (int i = 0; i < NI; i++) begin
            bit cap;
            cap = 1'b0;
            if (m_valid[i]) begin
                if (ready) begin
                    m_ptr[i]   = (m_ch[i] + 1 >= sz[i]) ? 0 : m_ch[i] + 1;
                    m_valid[i] = 1'b0;
                    if (!en)             m_idle[i] = 1'b1;
                    else if (dw[i] == 0) cap = 1'b1;
                    else                 m_left[i] = dw[i];
                end
            end else if (m_idle[i]) begin
                cap = en;
            end else if (!en) begin
                m_idle[i] = 1'b1;
            end else begin
                m_left[i] = m_left[i] - 1;
                cap = (m_left[i] == 0);
            end
            if (cap) begin
                m_idle[i]  = 1'b0;
                m_valid[i] = 1'b1;
                m_ch[i]    = mode ? m_ptr[i] : int'(sel);
                m_err[i]   = !mode && (int'(sel) >= sz[i]);
                m_out[i]   = m_err[i] ? 0 : int'((in_v >> (4 * m_ch[i])) & 32'hF);
            end
        end
    endfunction

    task automatic check_all(input string ph);
        logic       v, e;
        logic [3:0] o;
        logic [2:0] c;
        for (int i = 0; i < NI; i++) begin
            case (i)
                0:       begin v = a_valid; o = a_out; c = a_ch; e = a_err; end
                1:       begin v = b_valid; o = b_out; c = b_ch; e = b_err; end
                default: begin v = c_valid; o = c_out; c = c_ch; e = c_err; end
            endcase
            check($sformatf("%s.valid[%0d]", ph, i), 32'(v), 32'(m_valid[i]));
            if (m_valid[i]) begin
                check($sformatf("%s.out[%0d]", ph, i), 32'(o), 32'(m_out[i]));
                check($sformatf("%s.ch[%0d]", ph, i), 32'(c), 32'(m_ch[i]));
                check($sformatf("%s.err[%0d]", ph, i), 32'(e), 32'(m_err[i]));
            end
        end
    endtask

    task automatic check_reset(input string ph);
        check({ph, ".a"}, {a_valid, a_err, 3'(a_ch), 4'(a_out)}, 32'd0);
        check({ph, ".b"}, {b_valid, b_err, 3'(b_ch), 4'(b_out)}, 32'd0);
        check({ph, ".c"}, {c_valid, c_err, 3'(c_ch), 4'(c_out)}, 32'd0);
    endtask

    task automatic step(input int n, input string ph);
        repeat (n) begin
            @(posedge clk);
            model_step();
            #1;
            check_all(ph);
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel = 3'd0; ready = 1'b1;
        in_v  = 32'h7654_3210;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        @(negedge clk) rst_n = 1'b1;
        step(2, "idle");

        // Manual select, then a select change between captures.
        en = 1'b1; mode = 1'b0; sel = 3'd5;
        step(1, "man5_first");
        check("man5.a_out", 32'(a_out), 32'd5);
        check("man5.a_ch", 32'(a_ch), 32'd5);
        check("man5.a_valid", 32'(a_valid), 32'd1);
        step(6, "man5");
        sel = 3'd2;
        step(6, "man2");

        // Auto scan with ready high.
        mode = 1'b1;
        step(20, "scan");

        // Back-pressure while inputs change underneath the held sample.
        ready = 1'b0;
        repeat (5) begin
            in_v = $urandom;
            step(1, "bp");
        end
        ready = 1'b1; in_v = 32'h7654_3210;
        step(8, "bp_rel");

        // Drop en, then capture an out-of-range select from idle.
        en = 1'b0;
        step(4, "en_off");
        en = 1'b1; mode = 1'b0; sel = 3'd6;
        step(1, "sel6");
        check("sel6.c_err", 32'(c_err), 32'd1);
        check("sel6.c_ch", 32'(c_ch), 32'd6);
        check("sel6.c_out", 32'(c_out), 32'd0);
        check("sel6.a_out", 32'(a_out), 32'd6);
        check("sel6.a_err", 32'(a_err), 32'd0);

        // en dropped while the sample is stalled: held until accepted, then idle.
        ready = 1'b0; en = 1'b0;
        step(3, "hold");
        check("hold.a_valid", 32'(a_valid), 32'd1);
        check("hold.a_out", 32'(a_out), 32'd6);
        ready = 1'b1;
        step(3, "drain");
        check("drain.a_valid", 32'(a_valid), 32'd0);

        // Scan resumes after the last channel; the SIZE=5 instance wraps.
        en = 1'b1; mode = 1'b1;
        step(15, "scan5");

        repeat (400) begin
            en    = ($urandom_range(0, 9) != 0);
            mode  = 1'($urandom_range(0, 1));
            sel   = 3'($urandom);
            ready = ($urandom_range(0, 3) != 0);
            in_v  = $urandom;
            step(1, "rand");
        end

        // Asynchronous reset in the middle of a stalled sample.
        en = 1'b1; mode = 1'b1; ready = 1'b0; in_v = 32'h7654_3210;
        step(6, "pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset("async_rst");
        @(negedge clk) rst_n = 1'b1;
        ready = 1'b1;
        step(1, "post_rst_first");
        check("post_rst.a_ch", 32'(a_ch), 32'd0);
        check("post_rst.b_ch", 32'(b_ch), 32'd0);
        step(12, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
